// File: rtl/cla_multicycle_adder_ctrl.sv
// Multi-cycle wide adder/subtractor built from one narrow lookahead-carry
// slice. The slice is reused once per cycle, from the LSB slice to the MSB
// slice. Its carry-out is registered between cycles and becomes the carry-in
// of the next slice.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | adding slice cnt this cycle; in_valid ignored
// DONE  | result held on the outputs until out_ready; out_valid high
module cla_multicycle_adder_ctrl #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sum_r;
   logic             c_out_r;
   logic             ovf_r;
   logic             zero_r;

   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE:0]   c;
   logic [SLICE-1:0] s;

   // Pick the operand slice addressed by the counter.
   always_comb begin
      sa = '0;
      sb = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (cnt == CW'(k)) begin
            sa = opa[k*SLICE +: SLICE];
            sb = opb[k*SLICE +: SLICE];
         end
      end
   end

   // Lookahead carries for the slice, seeded by the registered carry.
   always_comb begin
      g    = sa & sb;
      p    = sa | sb;
      c    = '0;
      c[0] = carry;
      for (int i = 0; i < SLICE; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign s = sa ^ sb ^ c[SLICE-1:0];

   // Handshake sequencing, slice accumulation and result flag capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         opa     <= '0;
         opb     <= '0;
         sum_r   <= '0;
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               for (int k = 0; k < NSLICE; k++) begin
                  if (cnt == CW'(k)) sum_r[k*SLICE +: SLICE] <= s;
               end
               carry <= c[SLICE];
               if (cnt == LAST) begin
                  c_out_r <= c[SLICE];
                  ovf_r   <= c[SLICE-1] ^ c[SLICE];
                  // Lower slices are already in sum_r; the top slice is still combinational.
                  zero_r  <= (sum_r[WIDTH-SLICE-1:0] == '0) && (s == '0);
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign sum       = sum_r;
   assign c_out     = c_out_r;
   assign overflow  = ovf_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_cla_multicycle_adder_ctrl.sv
// Bench for cla_multicycle_adder_ctrl: directed vector table, random
// operations against an arithmetic reference, backpressure and async reset.
module tb_cla_multicycle_adder_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        c_out;
   logic        overflow;
   logic        zero;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] e_sum;
      logic        e_cout;
      logic        e_ovf;
      logic        e_zero;
   } vec_t;

   vec_t vecs[6];

   cla_multicycle_adder_ctrl #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic, signed overflow from operand/result signs.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic msub,
                        output logic [31:0] rs, output logic rc, output logic ro, output logic rz);
      logic [32:0] full;
      longint sa, sb, sr;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      sr = msub ? (sa - sb) : (sa + sb);
      full = msub ? ({1'b0, ma} + {1'b0, ~mb} + 33'd1) : ({1'b0, ma} + {1'b0, mb});
      rs = full[31:0];
      rc = full[32];
      ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      rz = (rs == 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation, wait for the result, return it and the latency.
   task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic osub,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output logic rz, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      a = oa; b = ob; sub = osub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      rs = sum; rc = c_out; ro = overflow; rz = zero;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rs, ms, keep_sum;
      logic        rc, ro, rz, mc, mo, mz;
      int          lat;

      vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      #22;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_flags", {61'd0, c_out, overflow, zero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, rz, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].e_sum));
         check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].e_cout));
         check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].e_ovf));
         check($sformatf("vec%0d_zero", i), 64'(rz), 64'(vecs[i].e_zero));
         check($sformatf("vec%0d_outv_drop", i), 64'(out_valid), 64'd0);
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         logic        rsub;
         ra = $urandom; rb = $urandom; rsub = 1'($urandom_range(0, 1));
         if (i % 8 == 3) rb = rsub ? ra : (~ra + 32'd1);
         if (i % 8 == 5) ra = 32'h7FFFFF00 | 32'($urandom_range(0, 255));
         model(ra, rb, rsub, ms, mc, mo, mz);
         run_op(ra, rb, rsub, rs, rc, ro, rz, lat);
         check($sformatf("rnd%0d_sum", i), 64'(rs), 64'(ms));
         check($sformatf("rnd%0d_cout", i), 64'(rc), 64'(mc));
         check($sformatf("rnd%0d_ovf", i), 64'(ro), 64'(mo));
         check($sformatf("rnd%0d_zero", i), 64'(rz), 64'(mz));
      end

      // Backpressure: hold DONE for 3 cycles while new operands wait.
      a = 32'h00001234; b = 32'h00000011; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd4);
      keep_sum = sum;
      check("bp_sum", 64'(keep_sum), 64'h1245);
      a = 32'd10; b = 32'd20; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
         check($sformatf("bp_hold%0d_sum", i), 64'(sum), 64'(keep_sum));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      check("bp_result_kept", 64'(sum), 64'(keep_sum));
      tick();
      in_valid = 1'b0;
      check("bp_accept_busy", 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_pending_latency", 64'(lat), 64'd4);
      check("bp_pending_sum", 64'(sum), 64'd30);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Async reset after the second slice has been written.
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_partial_sum", 64'(sum[15:0]), 64'h6789);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_sum", 64'(sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_op(32'd3, 32'd4, 1'b0, rs, rc, ro, rz, lat);
      check("post_rst_latency", 64'(lat), 64'd4);
      check("post_rst_sum", 64'(rs), 64'd7);
      check("post_rst_flags", {61'd0, rc, ro, rz}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
